// File: rtl/bram_stream_if.sv
// Stream-reader bundle: control, BRAM read port and valid/ready output stream.
// master is the reader side, slave is the environment (controller, BRAM, consumer).
interface bram_stream_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 64
);
  logic                 start;
  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS:0]   count;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] mem_rd_addr;
  logic [DATA_BITS-1:0] mem_rd_data;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_rdy;

  modport master (
    input  start, base_addr, count, mem_rd_data, out_rdy,
    output busy, done, mem_rd_addr, out_data, out_valid
  );

  modport slave (
    output start, base_addr, count, mem_rd_data, out_rdy,
    input  busy, done, mem_rd_addr, out_data, out_valid
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams count words starting at base_addr out of a 1-cycle-latency BRAM as a
// valid/ready stream, hiding the read latency behind a 2-entry output buffer.
module bram_stream_reader #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 64
) (
  input  logic          clk,
  input  logic          reset,
  bram_stream_if.master bus
);
  localparam int unsigned CW = ADDR_BITS + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] next_addr_q, next_addr_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]        issue_rem_q, issue_rem_d;
  logic [CW-1:0]        pop_rem_q, pop_rem_d;
  logic                 addr_live_q, addr_live_d;  // address on the port this cycle is a real read
  logic                 data_live_q, data_live_d;  // mem_rd_data this cycle belongs to a read
  logic [1:0]           occ_q, occ_d;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic [DATA_BITS-1:0] tail_q, tail_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 pop_c;
  logic                 push_c;
  logic                 issue_c;
  logic [2:0]           load_c;

  assign pop_c   = valid_q & bus.out_rdy;
  assign push_c  = data_live_q & (state_q == S_RUN);
  // Words buffered or in flight after this cycle's pop; a new read must keep it at or below 2.
  assign load_c  = 3'(occ_q) + 3'(addr_live_q) + 3'(data_live_q) - 3'(pop_c);
  assign issue_c = (state_q == S_RUN) && (issue_rem_q != '0) && (load_c < 3'd2);

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    rd_addr_d   = rd_addr_q;
    issue_rem_d = issue_rem_q;
    pop_rem_d   = pop_rem_q;
    addr_live_d = 1'b0;
    data_live_d = addr_live_q;
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            state_d = S_FINISH;
          end else begin
            // First read goes out on the accepting edge so the address is visible next cycle.
            state_d     = S_RUN;
            rd_addr_d   = bus.base_addr;
            next_addr_d = bus.base_addr + ADDR_BITS'(1);
            issue_rem_d = bus.count - CW'(1);
            pop_rem_d   = bus.count;
            addr_live_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue_c) begin
          rd_addr_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_BITS'(1);
          issue_rem_d = issue_rem_q - CW'(1);
          addr_live_d = 1'b1;
        end
        if (pop_c) begin
          pop_rem_d = pop_rem_q - CW'(1);
          if (pop_rem_q == CW'(1)) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Head/tail buffer: head is always the word presented on out_data.
    unique case ({push_c, pop_c})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.mem_rd_data;
        else               tail_d = bus.mem_rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.mem_rd_data;
        end else begin
          head_d = tail_q;
          tail_d = bus.mem_rd_data;
        end
      end
      default: ;
    endcase

    valid_d = (occ_d != 2'd0);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      rd_addr_q   <= '0;
      issue_rem_q <= '0;
      pop_rem_q   <= '0;
      addr_live_q <= 1'b0;
      data_live_q <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      rd_addr_q   <= rd_addr_d;
      issue_rem_q <= issue_rem_d;
      pop_rem_q   <= pop_rem_d;
      addr_live_q <= addr_live_d;
      data_live_q <= data_live_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.out_data    = head_q;
  assign bus.out_valid   = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader: a BRAM model, a transaction-level
// reference (expected word queue, done/busy phases) and literal anchor checks.
module tb_bram_stream_reader;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FIN  = 2;

  logic clk;
  logic reset;

  bram_stream_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  bram_stream_reader #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [256];
  logic [DW-1:0] expq[$];
  logic [DW-1:0] got_log[$];
  logic [AW-1:0] addr_log[$];

  int            n_checks = 0;
  int            n_pass   = 0;
  int            m_state  = M_IDLE;
  logic [AW-1:0] m_base   = '0;
  int            m_cnt    = 0;
  int            m_popped = 0;
  int            rdy_mode = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered-read BRAM.
  always @(posedge clk) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  task automatic check_eq(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
  endtask

  task automatic check_true(input string nm, input bit ok, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, limit/expected %0d at %0t", nm, act, req, $time);
  endtask

  // Consumer ready pattern: always ready, or a random 50% pattern.
  initial begin
    bus.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    bit pop;
    int issued;
    if (reset) begin
      m_state    = M_IDLE;
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      check_eq("busy", 64'(bus.busy), 64'(m_state == M_RUN));
      check_eq("done", 64'(bus.done), 64'(m_state == M_FIN));
      if (m_state != M_RUN) check_eq("valid_outside_run", 64'(bus.out_valid), 64'd0);
      if (prev_stall) begin
        check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
        check_eq("stall_data", bus.out_data, prev_data);
      end
      if (m_state == M_RUN) begin
        issued = int'(AW'(bus.mem_rd_addr - m_base)) + 1;
        check_true("readahead", (issued - m_popped) <= 2, issued - m_popped, 2);
        if (addr_log.size() == 0 || addr_log[$] != bus.mem_rd_addr)
          addr_log.push_back(bus.mem_rd_addr);
      end
      pop = bus.out_valid && bus.out_rdy;
      if (pop) begin
        if (expq.size() == 0) check_true("extra_word", 1'b0, 64'(bus.out_data), 0);
        else check_eq("word", bus.out_data, expq.pop_front());
        got_log.push_back(bus.out_data);
        m_popped++;
      end
      prev_stall = bus.out_valid && !bus.out_rdy;
      prev_data  = bus.out_data;
      case (m_state)
        M_IDLE: if (bus.start) begin
          m_base   = bus.base_addr;
          m_cnt    = int'(bus.count);
          m_popped = 0;
          expq.delete();
          for (int i = 0; i < m_cnt; i++) expq.push_back(mem[AW'(m_base + AW'(i))]);
          m_state = (m_cnt == 0) ? M_FIN : M_RUN;
        end
        M_RUN:  if (pop && m_popped == m_cnt) m_state = M_FIN;
        default: m_state = M_IDLE;
      endcase
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
    got_log.delete();
    addr_log.delete();
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.count     = c;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.count     = (AW + 1)'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (m_state == M_IDLE) return;
    end
    check_true("timeout", 1'b0, budget, 0);
  endtask

  initial begin
    logic [DW-1:0] basic_exp [4];
    logic [AW-1:0] wrap_exp  [4];
    basic_exp = '{64'h110, 64'h121, 64'h132, 64'h143};
    wrap_exp  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) mem[i] = 64'(i) * 64'h11;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_data", bus.out_data, 64'd0);
    check_eq("rst_addr", 64'(bus.mem_rd_addr), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic stream, consumer always ready.
    rdy_mode = 0;
    do_start(8'h10, 9'd4);
    @(negedge clk);
    check_eq("c1_busy", 64'(bus.busy), 64'd1);
    check_eq("c1_addr", 64'(bus.mem_rd_addr), 64'h10);
    @(negedge clk);
    check_eq("c2_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_eq("c3_valid", 64'(bus.out_valid), 64'd1);
    check_eq("c3_data", bus.out_data, 64'h110);
    wait_idle(100);
    check_eq("basic_len", 64'(got_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_log.size(); i++) check_eq("basic_word", got_log[i], basic_exp[i]);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check_eq("basic_addr", 64'(addr_log[i]), 64'(8'h10 + 8'(i)));

    // Zero-length transfer.
    do_start(8'h33, 9'd0);
    @(negedge clk);
    check_eq("zero_done", 64'(bus.done), 64'd1);
    check_eq("zero_busy", 64'(bus.busy), 64'd0);
    check_eq("zero_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check_eq("zero_done_off", 64'(bus.done), 64'd0);
    wait_idle(20);

    // Address wrap.
    do_start(8'hFE, 9'd4);
    wait_idle(100);
    check_eq("wrap_nаddr", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check_eq("wrap_addr", 64'(addr_log[i]), 64'(wrap_exp[i]));
    for (int i = 0; i < 4 && i < got_log.size(); i++) check_eq("wrap_word", got_log[i], 64'(wrap_exp[i]) * 64'h11);

    // Random contents and back-pressure from here on.
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    rdy_mode = 1;
    do_start(8'h20, 9'd16);
    wait_idle(400);
    check_eq("bp_len", 64'(got_log.size()), 64'd16);

    for (int t = 0; t < 6; t++) begin
      rdy_mode = int'($urandom_range(0, 1));
      do_start(AW'($urandom), (AW + 1)'($urandom_range(1, 40)));
      wait_idle(1000);
    end

    rdy_mode = 1;
    do_start(AW'($urandom), 9'd256);
    wait_idle(4000);
    check_eq("full_len", 64'(got_log.size()), 64'd256);

    // Start while busy is ignored.
    do_start(8'h80, 9'd8);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = 8'h05;
    bus.count = 9'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle(400);
    check_eq("busy_start_len", 64'(got_log.size()), 64'd8);
    if (addr_log.size() > 0) check_eq("busy_start_base", 64'(addr_log[0]), 64'h80);

    // Reset mid-transfer, then a fresh transfer.
    rdy_mode = 0;
    do_start(8'h60, 9'd8);
    for (int i = 0; i < 100 && m_popped < 2; i++) @(negedge clk);
    check_true("popped_before_reset", m_popped >= 2, m_popped, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_rst_addr", 64'(bus.mem_rd_addr), 64'd0);
    do_start(8'h40, 9'd3);
    wait_idle(100);
    check_eq("post_rst_len", 64'(got_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < addr_log.size(); i++) check_eq("post_rst_addr", 64'(addr_log[i]), 64'(8'h40 + 8'(i)));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
